// File: rtl/ex_mem_align_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_align_stage
// Brief   : EX pipeline stage: multi-cycle ALU handshake, memory alignment
//           check, byte-strobe/lane generation and the data-memory request.
// Revision: 1.0 - initial release
// ============================================================================
module ex_mem_align_stage #(
  parameter int DW    = 32,
  parameter int OFF_W = $clog2(DW / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              ex_allowin,
  input  logic [DW+42:0]    in_bus,
  output logic              fu_req,
  input  logic              fu_done,
  input  logic [DW-1:0]     fu_result,
  output logic              mem_req,
  output logic [DW/8-1:0]   mem_wstrb,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              out_allowin,
  output logic              out_valid,
  output logic [DW+42:0]    out_bus,
  output logic [DW+6:0]     fwd_bus
);

  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FU_WAIT = 2'd1,
    MEM_REQ = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   r_pc;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [DW-1:0] r_st_data;
  logic [DW-1:0] r_result;
  logic          r_ale;
  logic          r_first;

  logic          w_capture;
  logic          w_valid;
  logic          w_mem_op;
  logic          w_mis;
  logic          w_ale;
  logic [15:0]   w_strb_wide;

  assign ex_allowin = (state == IDLE) | ((state == DONE) & out_allowin);
  assign w_capture  = in_valid & ex_allowin & ~flush;
  assign w_valid    = (state != IDLE);
  assign w_mem_op   = r_mem_rd | r_mem_wr;

  // A doubleword access cannot be expressed on a 32-bit datapath, so it is
  // always treated as misaligned there.
  always_comb begin
    w_mis = 1'b0;
    case (r_size)
      2'd0:    w_mis = 1'b0;
      2'd1:    w_mis = fu_result[0];
      2'd2:    w_mis = |fu_result[1:0];
      default: w_mis = (DW == 32) ? 1'b1 : |fu_result[2:0];
    endcase
  end

  assign w_ale = w_mem_op & w_mis;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (w_capture) state_nxt = FU_WAIT;
      FU_WAIT: if (fu_done) state_nxt = (w_mem_op & ~w_ale) ? MEM_REQ : DONE;
      MEM_REQ: if (mem_addr_ok) state_nxt = DONE;
      DONE:    if (out_allowin) state_nxt = w_capture ? FU_WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      r_pc       <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_st_data  <= '0;
      r_result   <= '0;
      r_ale      <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      state   <= state_nxt;
      r_first <= 1'b0;
      if (w_capture) begin
        {r_pc, r_rf_we, r_rf_waddr, r_mem_rd, r_mem_wr, r_size, r_uns, r_st_data} <= in_bus;
        r_result <= '0;
        r_ale    <= 1'b0;
        r_first  <= 1'b1;
      end else if ((state == FU_WAIT) && fu_done && !flush) begin
        r_result <= fu_result;
        r_ale    <= w_ale;
      end
    end
  end

  // Requests are suppressed combinationally so a kill never leaks a transaction.
  assign fu_req  = (state == FU_WAIT) & r_first & ~flush & resetn;
  assign mem_req = (state == MEM_REQ) & ~flush & resetn;

  assign mem_addr    = r_result;
  assign w_strb_wide = ((16'd1 << (5'd1 << r_size)) - 16'd1) << r_result[OFF_W-1:0];
  assign mem_wstrb   = r_mem_wr ? w_strb_wide[NB-1:0] : '0;

  always_comb begin
    case (r_size)
      2'd0:    mem_wdata = {NB{r_st_data[7:0]}};
      2'd1:    mem_wdata = {(NB/2){r_st_data[15:0]}};
      2'd2:    mem_wdata = {(NB/4){r_st_data[31:0]}};
      default: mem_wdata = r_st_data;
    endcase
  end

  assign out_valid = (state == DONE);
  assign out_bus   = {r_pc, r_rf_we, r_rf_waddr, r_mem_rd, r_uns, r_size, r_ale, r_result};
  assign fwd_bus   = {r_mem_rd & w_valid, r_rf_we & w_valid, r_rf_waddr, r_result};

endmodule
`default_nettype wire

// File: doc/ex_mem_align_stage.md
EX_MEM_ALIGN_STAGE -- requirements
Module: ex_mem_align_stage

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving datapath width; legal values are 32 and 64, and NB = DW/8.
REQ-002 The block SHALL have parameter OFF_W, default log2(NB), giving the byte-offset width.
REQ-003 The block SHALL have port clk  input  1  clock; reset is resetn, synchronous, active-low; clock is clk.
REQ-004 The block SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port flush  input  1  kill the in-flight instruction (exception/branch redirect).
REQ-006 The block SHALL have port in_valid  input  1  upstream has an instruction.
REQ-007 The block SHALL have port ex_allowin  output  1  stage accepts an instruction this cycle.
REQ-008 The block SHALL have port in_bus  input  DW+43  {pc[31:0], rf_we, rf_waddr[4:0], mem_rd, mem_wr, size[1:0], unsigned, st_data[DW-1:0]}, MSB first.
REQ-009 The block SHALL have port fu_req  output  1  one-cycle start pulse to the multi-cycle ALU.
REQ-010 The block SHALL have port fu_done  input  1  ALU result valid.
REQ-011 The block SHALL have port fu_result  input  DW  ALU result (effective address for memory ops).
REQ-012 The block SHALL have port mem_req  output  1  data memory request.
REQ-013 The block SHALL have port mem_wstrb  output  NB  byte write strobes; all-zero for loads.
REQ-014 The block SHALL have port mem_addr  output  DW  request address.
REQ-015 The block SHALL have port mem_wdata  output  DW  lane-replicated store data.
REQ-016 The block SHALL have port mem_addr_ok  input  1  memory accepted the request this cycle.
REQ-017 The block SHALL have port out_allowin  input  1  downstream stage can accept.
REQ-018 The block SHALL have port out_valid  output  1  out_bus is valid.
REQ-019 The block SHALL have port out_bus  output  DW+43  {pc, rf_we, rf_waddr, mem_rd, unsigned, size, ale, result[DW-1:0], pad to width with zeros}.
REQ-020 The block SHALL have port fwd_bus  output  DW+7  {is_load&valid, rf_we&valid, rf_waddr, result} for ID bypass/interlock.

Function
REQ-021 The block SHALL implement states IDLE, FU_WAIT, MEM_REQ and DONE; "valid" means state != IDLE.
REQ-022 The block SHALL define ex_allowin = (state==IDLE) | (state==DONE & out_allowin), combinationally.
REQ-023 The block SHALL capture in_bus and enter FU_WAIT when in_valid & ex_allowin; otherwise a DONE state that hands off goes to IDLE.
REQ-024 The block SHALL assert fu_req only in the first cycle of FU_WAIT.
REQ-025 The block SHALL sample fu_done in every FU_WAIT cycle, including the fu_req cycle, capture fu_result into the result register, and ignore fu_done in all other states.
REQ-026 The block SHALL compute ale on fu_done as (mem_rd|mem_wr) & (addr[size-1:0] != 0), with size 11 forced to ale=1 when DW=32.
REQ-027 On fu_done the block SHALL go to MEM_REQ if (mem_rd|mem_wr) & ~ale, else to DONE.
REQ-028 In MEM_REQ the block SHALL hold mem_req=1 with stable mem_addr, mem_wstrb and mem_wdata until mem_addr_ok, then go to DONE; a misaligned access SHALL never issue mem_req.
REQ-029 The block SHALL drive mem_wstrb = mem_wr ? (((1<<(1<<size))-1) << addr[OFF_W-1:0]) : 0, truncated to NB bits.
REQ-030 The block SHALL drive mem_wdata as st_data's low (8<<size) bits replicated across DW.
REQ-031 The block SHALL drive out_valid = (state==DONE), with out_bus fields taken from the captured registers.
REQ-032 The block SHALL hold DONE with out_bus stable while out_allowin=0.
REQ-033 When DONE hands off and a new capture occurs in the same cycle, the block SHALL go directly to FU_WAIT with no bubble.
REQ-034 The block SHALL drive fwd_bus with valid-gated is_load/rf_we; result is meaningful only in MEM_REQ/DONE.
REQ-035 On flush the block SHALL go to IDLE next cycle, drop the instruction, and gate mem_req and fu_req to 0 combinationally in the flush cycle.
REQ-036 On flush | ~resetn the block SHALL ignore any capture in that same cycle.

Reset
REQ-037 While resetn=0 at a clk edge, the block SHALL set state to IDLE and all captured registers to 0, so that out_valid, mem_req, fu_req, mem_wstrb and fwd_bus valid bits are all 0; resetn mid-operation SHALL abandon the instruction without issuing a request.

Verification
REQ-038 The bench SHALL cover: DW=32, sh with addr 0x1002, st_data 0x1234ABCD, fu_done after 3 cycles -> one mem_req, wstrb 1100, wdata 0xABCDABCD; out_valid 1 cycle after mem_addr_ok.
REQ-039 The bench SHALL cover: ld.w with addr 0x1001 -> ale=1, no mem_req, out_valid with ale set.
REQ-040 The bench SHALL cover: mem_addr_ok low for 4 cycles -> mem_req held and address/strobes stable for 5 cycles; ex_allowin=0 throughout.
REQ-041 The bench SHALL cover: back-to-back ALU ops with fu_done in the fu_req cycle and out_allowin=1 -> one result per 2 cycles, with no bubble between hand-off and the next capture.
REQ-042 The bench SHALL cover: flush asserted in MEM_REQ -> mem_req 0 in the same cycle, state IDLE next cycle, and a later fu_done ignored.
REQ-043 The bench SHALL cover: DW=64, sb with addr 0x7 -> wstrb 0x80 and wdata holding the byte in all 8 lanes.
